vec_multicycle_ctrl: RTL

//  Multicycle main controller for the ARM core with vector extension.

---
 rtl/vec_mc_defs.sv | 62 ++++++
 rtl/vec_lane_counter.sv | 49 ++++
 rtl/vec_multicycle_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vec_mc_defs.sv
`default_nettype none
// ============================================================================
//  Package  : vec_mc_defs
//  Purpose  : Shared encodings for the vector multicycle controller: FSM
//             state codes, instruction Op codes, Funct[4:1] constants and
//             datapath selector codes, plus small instruction classifiers.
//  Revision : 1.0  initial release
// ============================================================================
package vec_mc_defs;

    // Controller states, 4-bit encoding
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_VEXEC  = 4'd9,
        S_BRANCH = 4'd10
    } state_t;

    // Instruction class, instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Funct[4:1] codes that look vector-like but are scalar moves
    localparam logic [3:0] FN_MOV    = 4'b1110;
    localparam logic [3:0] FN_MOVIDX = 4'b1101;

    // ALUSrcA selector
    localparam logic [1:0] SRCA_RN = 2'b00;
    localparam logic [1:0] SRCA_PC = 2'b01;

    // ALUSrcB selector
    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc selector
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // A data-processing Funct selects the vector path when bit 4 is set,
    // except for the two scalar move encodings that share that bit.
    function automatic logic is_vector_op(input logic [5:0] funct);
        return funct[4] && (funct[4:1] != FN_MOV) && (funct[4:1] != FN_MOVIDX);
    endfunction

    // MOVIDX is the immediate form of the 1101 encoding
    function automatic logic is_movidx(input logic [5:0] funct);
        return funct[5] && (funct[4:1] == FN_MOVIDX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_lane_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vec_lane_counter
//  Purpose  : Active-lane index for vector execution. Clears to zero,
//             advances by one when enabled, wraps after the last lane and
//             flags the terminal lane.
//  Revision : 1.0  initial release
// ============================================================================
module vec_lane_counter #(
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // Next index: clear wins, otherwise advance and wrap on the last lane
    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (en_i) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Index register; holds whenever neither clear nor enable is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/vec_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vec_multicycle_ctrl
//  Purpose  : Multicycle main controller for the ARM core with vector
//             extension. Sequences fetch/decode/execute/memory/writeback,
//             stalls on the memory-ready handshake and walks vector ops one
//             lane per cycle. ALU decode is external and keyed by ALUOp.
//  Revision : 1.0  initial release
// ============================================================================
module vec_multicycle_ctrl
    import vec_mc_defs::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic                  MemReady,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic                  ALUOp,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  VecWrite,
    output logic                  VecIdxWrite,
    output logic [LANE_IDX_W-1:0] LaneIdx,
    output logic                  InstrDone,
    output logic                  IllegalOp
);

    state_t state_q;
    state_t state_d;

    logic w_dp_vector;
    logic w_lane_clear;
    logic w_lane_en;
    logic w_lane_last;

    assign w_dp_vector  = (Op == OP_DP) && is_vector_op(Funct);
    // Lane index restarts at zero as a vector op leaves DECODE
    assign w_lane_clear = (state_q == S_DECODE) && w_dp_vector;
    assign w_lane_en    = (state_q == S_VEXEC);

    vec_lane_counter #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (LANE_IDX_W)
    ) u_lane_ctr (
        .clk     (clk),
        .rst     (reset),
        .clear_i (w_lane_clear),
        .en_i    (w_lane_en),
        .idx_o   (LaneIdx),
        .last_o  (w_lane_last)
    );

    // Next-state selection from current state, instruction fields and handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    OP_ILL:  state_d = S_FETCH;
                    default: begin
                        if (w_dp_vector)   state_d = S_VEXEC;
                        else if (Funct[5]) state_d = S_EXECI;
                        else               state_d = S_EXECR;
                    end
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (MemReady) state_d = S_FETCH;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_VEXEC:  if (w_lane_last) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register; an asynchronous reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath controls decoded from state; everything is forced low under reset
    always_comb begin
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = SRCA_RN;
        ALUSrcB     = SRCB_RM;
        ResultSrc   = RES_ALUOUT;
        ALUOp       = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        VecWrite    = 1'b0;
        VecIdxWrite = 1'b0;
        InstrDone   = 1'b0;
        IllegalOp   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                    IRWrite   = MemReady;
                    PCWrite   = MemReady;
                end
                S_DECODE: begin
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    IllegalOp = (Op == OP_ILL);
                    InstrDone = (Op == OP_ILL);
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RN;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = RES_RDATA;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_MEMWR: begin
                    // Write strobe stays up for the whole wait; memory takes it on MemReady
                    AdrSrc    = 1'b1;
                    MemWrite  = 1'b1;
                    InstrDone = MemReady;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_RN;
                    ALUSrcB = SRCB_RM;
                    ALUOp   = 1'b1;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_RN;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = 1'b1;
                end
                S_ALUWB: begin
                    ResultSrc = RES_ALUOUT;
                    InstrDone = 1'b1;
                    if (is_movidx(Funct)) begin
                        VecIdxWrite = 1'b1;
                    end else begin
                        RegWrite = 1'b1;
                        PCWrite  = (Rd == 4'd15);
                    end
                end
                S_VEXEC: begin
                    ALUSrcA   = SRCA_RN;
                    ALUSrcB   = Funct[5] ? SRCB_IMM : SRCB_RM;
                    ALUOp     = 1'b1;
                    VecWrite  = 1'b1;
                    InstrDone = w_lane_last;
                end
                S_BRANCH: begin
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALURES;
                    PCWrite   = 1'b1;
                    InstrDone = 1'b1;
                end
                default: begin
                    InstrDone = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
